// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and constants for the mux16 round-robin arbiter.
// MAX_HOLD only takes effect when ARB_HOLD_TIMEOUT_EN is defined.
package mux_arb_pkg;

  localparam int N_REQ    = 16;
  localparam int SEL_W    = 4;
  localparam int MAX_HOLD = 8;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] onehot(input sel_t idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_pick.sv
// Rotating first-one search: returns the first eligible index at or after
// start, wrapping 15 -> 0.
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  sel_t             start,
  output logic             found,
  output sel_t             winner
);

  sel_t idx;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    found  = 1'b0;
    winner = start;
    idx    = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + sel_t'(i);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux.
// Define ARB_HOLD_TIMEOUT_EN to force-release grants after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no grant; sel holds the last granted index
// GRANT | gnt[sel] owned until eligible[sel] drops (or hold timeout)
module mux16_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] gnt,
  output sel_t             sel,
  output logic             gnt_valid,
  output logic             busy
);

  arb_state_t       state;
  sel_t             ptr;
  sel_t             pick_start;
  sel_t             winner;
  logic             found;
  logic             release_now;
  logic [N_REQ-1:0] eligible;

  assign eligible = req & mask;

  // A release search starts just past the owner so the owner is considered last.
  assign pick_start = (state == GRANT) ? sel + sel_t'(1) : ptr;

  rr_pick16 u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .found    (found),
    .winner   (winner)
  );

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign release_now = !eligible[sel] || (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign release_now = !eligible[sel];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      ptr       <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= onehot(winner);
            sel       <= winner;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= sel + sel_t'(1);
            if (found) begin
              gnt       <= onehot(winner);
              sel       <= winner;
`ifdef ARB_HOLD_TIMEOUT_EN
              hold_cnt  <= '0;
`endif
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus random
// traffic compared every cycle against a queue-free ownership model.
module tb_mux16_rr_arbiter;
  import mux_arb_pkg::*;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mask;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        gnt_valid;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  // Reference model: owner index (-1 when idle), last select, search start, hold age.
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_hold;

  always #5 clk = ~clk;

  mux16_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [15:0] elig, input int start);
    for (int k = 0; k < 16; k++)
      if (elig[(start + k) % 16]) return (start + k) % 16;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_sel   = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input logic [15:0] m);
    logic [15:0] elig;
    int w;
    elig = r & m;
    if (m_owner < 0) begin
      w = search(elig, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_hold  = 0;
      end
    end else if (!elig[m_owner] || (TO_EN && m_hold == MAX_HOLD - 1)) begin
      m_ptr = (m_owner + 1) % 16;
      w = search(elig, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_hold  = 0;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [15:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
    chk({ctx, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({ctx, ".sel"}, 32'(sel), 32'(m_sel));
    chk({ctx, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({ctx, ".busy"}, 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic cycle(input string ctx, input logic [15:0] r, input logic [15:0] m);
    req  = r;
    mask = m;
    @(posedge clk);
    model_step(r, m);
    #1;
    check_outputs(ctx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rr_req;
    logic [15:0] r;
    logic [15:0] m;
    int exp_order [5] = '{5, 7, 10, 12, 5};

    rst  = 1'b1;
    req  = '0;
    mask = 16'hffff;
    model_reset();
    #1;
    check_outputs("por");
    #12;
    rst = 1'b0;

    // Async reset in the middle of a grant clears outputs without an edge.
    cycle("rst_a", 16'h0020, 16'hffff);
    chk("rst_first_gnt", 32'(gnt), 32'h0020);
    cycle("rst_b", 16'h0020, 16'hffff);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_sel", 32'(sel), 32'h0);
    chk("rst_async_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_c", 16'h0020, 16'hffff);
    chk("rst_regrant_gnt", 32'(gnt), 32'h0020);
    chk("rst_regrant_sel", 32'(sel), 32'd5);

    // Round-robin over bits 5,7,10,12 with each owner dropping after 2 cycles.
    do_reset();
    rr_req = 16'h14A0;
    cycle("rr_start", rr_req, 16'hffff);
    foreach (exp_order[i]) begin
      chk("rr_order", 32'(sel), 32'(exp_order[i]));
      chk("rr_no_gap", 32'(gnt_valid), 32'h1);
      cycle("rr_hold", rr_req, 16'hffff);
      cycle("rr_drop", rr_req & ~(16'h1 << exp_order[i]), 16'hffff);
    end

    // Wrap-around: get ptr to 15, then 15 wins over 0, then 0, then ptr = 1.
    do_reset();
    cycle("wrap_a", 16'h4000, 16'hffff);
    cycle("wrap_b", 16'h0000, 16'hffff);
    cycle("wrap_c", 16'h8001, 16'hffff);
    chk("wrap_first15", 32'(gnt), 32'h8000);
    cycle("wrap_d", 16'h0001, 16'hffff);
    chk("wrap_then0", 32'(gnt), 32'h0001);
    cycle("wrap_e", 16'h0000, 16'hffff);
    cycle("wrap_f", 16'h0003, 16'hffff);
    chk("wrap_ptr1", 32'(gnt), 32'h0002);

    // Mask cleared mid-grant: hand off to 9, then idle with sel held at 7.
    do_reset();
    cycle("mask_a", 16'h0280, 16'hffff);
    chk("mask_own7", 32'(gnt), 32'h0080);
    cycle("mask_b", 16'h0280, 16'hff7f);
    chk("mask_pass9", 32'(gnt), 32'h0200);
    cycle("mask_c", 16'h0000, 16'hffff);
    cycle("mask_d", 16'h0080, 16'hffff);
    cycle("mask_e", 16'h0080, 16'hff7f);
    chk("mask_idle_gnt", 32'(gnt), 32'h0);
    chk("mask_idle_sel", 32'(sel), 32'd7);

    // Idle for a while, then a single request.
    for (int i = 0; i < 10; i++) cycle("idle", 16'h0000, 16'hffff);
    chk("idle_sel_kept", 32'(sel), 32'd7);
    cycle("single", 16'h0400, 16'hffff);
    chk("single_gnt", 32'(gnt), 32'h0400);
    chk("single_sel", 32'(sel), 32'd10);

`ifdef ARB_HOLD_TIMEOUT_EN
    do_reset();
    cycle("to_a", 16'h0208, 16'hffff);
    chk("to_first3", 32'(gnt), 32'h0008);
    for (int i = 0; i < MAX_HOLD; i++) cycle("to_alt", 16'h0208, 16'hffff);
    chk("to_then9", 32'(gnt), 32'h0200);
    for (int i = 0; i < 3 * MAX_HOLD; i++) cycle("to_alt", 16'h0208, 16'hffff);
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      cycle("to_solo", 16'h0008, 16'hffff);
      chk("to_solo_valid", 32'(gnt_valid), 32'h1);
    end
`endif

    // Random traffic with sticky requests and occasional mask churn.
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom);
      m = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hffff;
      cycle("rand", r, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
